sobol_pair_ctrl: RTL

Sequencer and configuration front-end for the dual-output Sobol generator in the stochastic-computing bitstream path. It holds the merged direction-vector table, clears the generator, and steps it once per accepted sample. It computes the per-step vector index (least-significant-zero of a step counter) and presents the run to a consumer through a valid/ready handshake with a last flag and a done pulse.

---
 rtl/sobol_pair_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sobol_pair_ctrl.sv
// Sequencer and direction-vector table for the dual-output Sobol generator.
// Optional macro SOBOL_CTRL_CFGLOCK_EN: reject table writes while busy and pulse cfg_err.
module sobol_pair_ctrl #(
  parameter int INWD    = 8,
  parameter int LOGINWD = 3,
  parameter int LENW    = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [LOGINWD-1:0]         cfg_addr,
  input  logic [INWD:0]              cfg_data,
  output logic                       cfg_err,
  output logic [INWD-1:0][INWD:0]    dir_vec,
  input  logic                       start,
  input  logic [LENW-1:0]            len,
  output logic                       busy,
  output logic                       done,
  output logic                       rng_clr,
  output logic                       rng_en,
  output logic [LOGINWD-1:0]         vec_idx0,
  output logic [LOGINWD-1:0]         vec_idx1,
  output logic                       smp_valid,
  input  logic                       smp_ready,
  output logic                       smp_last
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  localparam logic [LENW-1:0]    LEN_ONE  = LENW'(1);
  localparam logic [LOGINWD-1:0] IDX_CLMP = LOGINWD'(INWD - 1);

  state_t            state;
  logic [LENW-1:0]   cnt;
  logic [LENW-1:0]   len_q;
  logic [LENW-1:0]   last_cnt;
  logic              at_last;
  logic              fire;
  logic              in_run;
  logic              tbl_we;
  logic [LOGINWD-1:0] lsz_idx;

  assign last_cnt = len_q - LEN_ONE;
  assign at_last  = (cnt == last_cnt);
  assign in_run   = (state == RUN);
  assign fire     = smp_valid & smp_ready;

  // The last fire ends the run without stepping the generator.
  assign rng_en   = in_run & fire & ~at_last;
  assign smp_last = in_run & at_last;

  always_comb begin
    logic found;
    lsz_idx = IDX_CLMP;
    found   = 1'b0;
    for (int unsigned i = 0; i < INWD; i++) begin
      if (!found && !cnt[i]) begin
        lsz_idx = LOGINWD'(i);
        found   = 1'b1;
      end
    end
  end

  assign vec_idx0 = lsz_idx;
  assign vec_idx1 = lsz_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rng_clr   <= 1'b0;
      smp_valid <= 1'b0;
    end else begin
      done    <= 1'b0;
      rng_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              len_q   <= len;
              cnt     <= '0;
              busy    <= 1'b1;
              rng_clr <= 1'b1;
              state   <= CLEAR;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        CLEAR: begin
          smp_valid <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          if (fire) begin
            if (at_last) begin
              smp_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              cnt <= cnt + LEN_ONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SOBOL_CTRL_CFGLOCK_EN
  assign tbl_we = cfg_we & ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we & busy;
    end
  end
`else
  assign tbl_we  = cfg_we;
  assign cfg_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_vec <= '0;
    end else if (tbl_we) begin
      dir_vec[cfg_addr] <= cfg_data;
    end
  end

endmodule
